// File: rtl/proc_core_param.sv
// Purpose : parametrised accumulator core with fetch/exec/mem sequencer, one per array core.
// Latency : 2 cycles per non-memory instruction, 3 for LOAD/STORE (IM/DM read combinationally).
// Backpr. : status 1x/00 while running freezes all state; a blocked store is replayed on release.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   status[1:0]  scheduler handshake: 00 idle/release, 01 run, 1x stall
//   IM_out       instruction word at PC_out      DM_out  data word at AR_out
//   PC_out       program counter                 AR_out  data address register
//   bus          DM write data (DR), always driven
//   DM_write_en  single-cycle DM write strobe    end_process  high while in DONE
// Parameters: DATA_W (>= 12), ADDR_W (<= 12), NUM_GPR (2..8).
// Optional  : define PROC_CORE_HW_MUL_EN to give opcode 8 a hardware multiply; otherwise it is a NOP.
module proc_core_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int NUM_GPR = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        status,
  input  logic [15:0]       IM_out,
  input  logic [DATA_W-1:0] DM_out,
  output logic [ADDR_W-1:0] PC_out,
  output logic [ADDR_W-1:0] AR_out,
  output logic [DATA_W-1:0] bus,
  output logic              DM_write_en,
  output logic              end_process
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_MOV   = 4'h4;
  localparam logic [3:0] OP_MVA   = 4'h5;
  localparam logic [3:0] OP_ADD   = 4'h6;
  localparam logic [3:0] OP_SUB   = 4'h7;
`ifdef PROC_CORE_HW_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'h8;
`endif
  localparam logic [3:0] OP_INC   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JPNZ  = 4'hB;
  localparam logic [3:0] OP_END   = 4'hC;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   ar_q, ar_d;
  logic [DATA_W-1:0]   dr_q, dr_d;
  logic [15:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   ac_q, ac_d;
  logic [DATA_W-1:0]   gpr_q [NUM_GPR];
  logic [DATA_W-1:0]   gpr_d [NUM_GPR];

  logic                run;
  logic                z;
  logic [3:0]          op;
  logic [2:0]          rsel;
  logic [7:0]          imm8;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   gpr_rd;
  logic                dm_we;
  logic                end_proc;

  // Only 01 advances a running program; 00 and 1x both hold it in place.
  assign run  = (status == 2'b01);
  assign z    = (ac_q == '0);

  assign op   = ir_q[15:12];
  assign rsel = ir_q[11:9];
  assign imm8 = ir_q[7:0];
  assign addr = ir_q[ADDR_W-1:0];

  // Register indices beyond NUM_GPR have no storage and read back as zero.
  always_comb begin
    gpr_rd = '0;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (rsel == 3'(i)) gpr_rd = gpr_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ar_d     = ar_q;
    dr_d     = dr_q;
    ir_d     = ir_q;
    ac_d     = ac_q;
    gpr_d    = gpr_q;
    dm_we    = 1'b0;
    end_proc = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (run) begin
          ir_d    = IM_out;
          pc_d    = pc_q + 1'b1;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (run) begin
          state_d = S_FETCH;
          case (op)
            OP_LDI:   ac_d = DATA_W'(imm8);
            OP_LOAD: begin
              ar_d    = addr;
              state_d = S_MEM;
            end
            OP_STORE: begin
              ar_d    = addr;
              dr_d    = ac_q;
              state_d = S_MEM;
            end
            OP_MOV: begin
              for (int i = 0; i < NUM_GPR; i++) begin
                if (rsel == 3'(i)) gpr_d[i] = ac_q;
              end
            end
            OP_MVA:   ac_d = gpr_rd;
            OP_ADD:   ac_d = ac_q + gpr_rd;
            OP_SUB:   ac_d = ac_q - gpr_rd;
`ifdef PROC_CORE_HW_MUL_EN
            // DATA_W-wide context keeps only the low half of the product.
            OP_MUL:   ac_d = ac_q * gpr_rd;
`endif
            OP_INC:   ac_d = ac_q + DATA_W'(1);
            OP_JMP:   pc_d = addr;
            // z reflects AC before this instruction, i.e. the flag seen entering EXEC.
            OP_JPNZ:  if (!z) pc_d = addr;
            OP_END:   state_d = S_DONE;
            default:  ;
          endcase
        end
      end

      S_MEM: begin
        // IR still holds the memory instruction, so it selects load vs store here.
        if (op == OP_STORE) begin
          dm_we = run;
        end else if (run) begin
          ac_d = DM_out;
        end
        if (run) state_d = S_FETCH;
      end

      S_DONE: begin
        end_proc = 1'b1;
        if (status == 2'b00) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ar_q    <= '0;
      dr_q    <= '0;
      ir_q    <= '0;
      ac_q    <= '0;
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      dr_q    <= dr_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= gpr_d[i];
    end
  end

  assign PC_out      = pc_q;
  assign AR_out      = ar_q;
  assign bus         = dr_q;
  assign DM_write_en = dm_we;
  assign end_process = end_proc;

endmodule

// File: tb/tb_proc_core_param.sv
// Purpose : self-checking bench for proc_core_param against an instruction-level reference model.
// Latency : checks per-program cycle totals (2 per instruction, 3 per LOAD/STORE) when unstalled.
// Backpr. : drives random and directed stalls on status and checks state freezes and store replay.
module tb_proc_core_param;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int NG = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    status;
  logic [15:0]   IM_out;
  logic [DW-1:0] DM_out;
  logic [AW-1:0] PC_out;
  logic [AW-1:0] AR_out;
  logic [DW-1:0] bus;
  logic          DM_write_en;
  logic          end_process;

  always #5 clk = ~clk;

  proc_core_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_GPR(NG)) dut (
    .clk(clk), .rst(rst), .status(status), .IM_out(IM_out), .DM_out(DM_out),
    .PC_out(PC_out), .AR_out(AR_out), .bus(bus),
    .DM_write_en(DM_write_en), .end_process(end_process)
  );

  // External memories seen by the DUT.
  logic [15:0]   im [0:4095];
  logic [DW-1:0] dm [0:4095];
  assign IM_out = im[PC_out];
  assign DM_out = dm[AR_out];

  // Reference architectural state.
  logic [DW-1:0] m_dm  [0:4095];
  logic [DW-1:0] m_gpr [0:7];
  logic [DW-1:0] m_ac;
  logic [AW-1:0] m_pc;

  logic [AW-1:0] exp_a[$], got_a[$];
  logic [DW-1:0] exp_d[$], got_d[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input int lo);
    return {op, 12'(lo)};
  endfunction

  function automatic logic [15:0] rins(input logic [3:0] op, input int r);
    return {op, 3'(r), 9'h000};
  endfunction

  task automatic clear_im();
    for (int i = 0; i < 4096; i++) im[i] = 16'h0000;
  endtask

  task automatic model_reset();
    m_ac = '0;
    m_pc = '0;
    for (int i = 0; i < 8; i++) m_gpr[i] = '0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    status = 2'b10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Instruction-level execution of the program in im[] from m_pc until END.
  // lat accumulates the architectural cycle cost of each retired instruction.
  task automatic ref_run(output int lat);
    logic [15:0]   w;
    logic [3:0]    op;
    int            r;
    logic [AW-1:0] a;
    logic [DW-1:0] g;
    bit            fin;
    fin = 0;
    lat = 0;
    for (int s = 0; s < 2000 && !fin; s++) begin
      w    = im[m_pc];
      m_pc = m_pc + 1'b1;
      op   = w[15:12];
      r    = int'(w[11:9]);
      a    = w[AW-1:0];
      g    = (r < NG) ? m_gpr[r] : '0;
      lat += (op == 4'h2 || op == 4'h3) ? 3 : 2;
      case (op)
        4'h1: m_ac = DW'(w[7:0]);
        4'h2: m_ac = m_dm[a];
        4'h3: begin
          m_dm[a] = m_ac;
          exp_a.push_back(a);
          exp_d.push_back(m_ac);
        end
        4'h4: if (r < NG) m_gpr[r] = m_ac;
        4'h5: m_ac = g;
        4'h6: m_ac = m_ac + g;
        4'h7: m_ac = m_ac - g;
`ifdef PROC_CORE_HW_MUL_EN
        4'h8: m_ac = DW'((32'(m_ac) * 32'(g)) % (32'd1 << DW));
`endif
        4'h9: m_ac = m_ac + 1'b1;
        4'hA: m_pc = a;
        4'hB: if (m_ac != 0) m_pc = a;
        4'hC: fin = 1;
        default: ;
      endcase
    end
  endtask

  // mode 0: always run; 1: random stalls; 2: 4-cycle stall on first store strobe;
  // 3: assert reset on first store strobe.
  task automatic run_prog(input int mode, output int cyc, output bit done);
    logic [AW-1:0] prev_pc, prev_ar;
    logic [DW-1:0] prev_bus;
    bit            prev_stall;
    bit            used;
    int            stall_left;
    int            pick;
    got_a.delete();
    got_d.delete();
    cyc = 0; done = 0; used = 0; stall_left = 0; prev_stall = 0;
    prev_pc = '0; prev_ar = '0; prev_bus = '0;
    status = 2'b01;
    @(negedge clk);
    for (int n = 0; n < 4000; n++) begin
      if (end_process) begin
        done = 1;
        break;
      end
      if (prev_stall) begin
        check_val("stall_pc", PC_out, prev_pc);
        check_val("stall_ar", AR_out, prev_ar);
        check_val("stall_bus", bus, prev_bus);
      end
      prev_pc = PC_out; prev_ar = AR_out; prev_bus = bus;
      if (stall_left > 0) begin
        status = 2'b10;
        stall_left--;
      end else if (mode == 1 && $urandom_range(0, 9) < 4) begin
        pick   = $urandom_range(0, 2);
        status = (pick == 0) ? 2'b00 : (pick == 1) ? 2'b10 : 2'b11;
      end else begin
        status = 2'b01;
      end
      #1;
      if (DM_write_en && !used && mode >= 2) begin
        used = 1;
        if (mode == 2) begin
          status     = 2'b10;
          stall_left = 3;
          #1;
          check_val("stall_we", DM_write_en, 0);
        end else begin
          rst = 1'b1;
          #1;
          check_val("rst_we", DM_write_en, 0);
          check_val("rst_pc", PC_out, 0);
          check_val("rst_ar", AR_out, 0);
          check_val("rst_bus", bus, 0);
          check_val("rst_end", end_process, 0);
          break;
        end
      end
      prev_stall = (status != 2'b01);
      if (DM_write_en) begin
        check_val("we_status", status, 2'b01);
        got_a.push_back(AR_out);
        got_d.push_back(bus);
        dm[AR_out] = bus;
      end
      if (status == 2'b01) cyc++;
      @(negedge clk);
    end
    status = 2'b10;
  endtask

  task automatic compare_trace(input string tag);
    check_val({tag, "_nstore"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      check_val({tag, "_addr"}, got_a[i], exp_a[i]);
      check_val({tag, "_data"}, got_d[i], exp_d[i]);
    end
    exp_a.delete();
    exp_d.delete();
  endtask

  // Full program: model, DUT run, then trace/end/PC (and cycle count when unstalled).
  task automatic exec_check(input string tag, input int mode);
    int lat, cyc;
    bit done;
    ref_run(lat);
    run_prog(mode, cyc, done);
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_pc"}, PC_out, m_pc);
    if (mode == 0) check_val({tag, "_cycles"}, cyc, lat);
    compare_trace(tag);
  endtask

  task automatic release_done();
    status = 2'b00;
    @(negedge clk);
    status = 2'b10;
    m_pc   = '0;
    check_val("rel_pc", PC_out, 0);
    check_val("rel_end", end_process, 0);
  endtask

  task automatic gen_prog();
    int len;
    logic [3:0]  op;
    logic [11:0] lo;
    len = $urandom_range(6, 20);
    clear_im();
    for (int i = 0; i < len - 2; i++) begin
      op = 4'($urandom_range(0, 15));
      lo = 12'($urandom);
      if (op == 4'hC) op = 4'h9;
      if (op == 4'hA || op == 4'hB) lo = 12'($urandom_range(i + 1, len - 1));
      if (op == 4'h2 || op == 4'h3) lo = 12'($urandom_range(0, 63));
      im[i] = {op, lo};
    end
    im[len-2] = ins(4'h3, 12'h03F);
    im[len-1] = ins(4'hC, 0);
  endtask

  initial begin
    int cyc;
    bit done;
    logic [DW-1:0] mul_exp;

    for (int i = 0; i < 4096; i++) begin
      dm[i]   = DW'($urandom);
      m_dm[i] = dm[i];
    end
    clear_im();
    do_reset();

    check_val("reset_pc", PC_out, 0);
    check_val("reset_ar", AR_out, 0);
    check_val("reset_bus", bus, 0);
    check_val("reset_we", DM_write_en, 0);
    check_val("reset_end", end_process, 0);

    // Basic program: AC = 5 + 3, END after 10 cycles, PC = 5.
    im[0] = ins(4'h1, 5); im[1] = rins(4'h4, 1); im[2] = ins(4'h1, 3);
    im[3] = rins(4'h6, 1); im[4] = ins(4'hC, 0);
    exec_check("basic", 0);
    check_val("basic_pc_lit", PC_out, 5);
    // Release and rerun: AC survives, store exposes it.
    release_done();
    clear_im();
    im[0] = ins(4'h3, 12'h010); im[1] = ins(4'hC, 0);
    if (got_d.size() >= 0) exec_check("rerun", 0);
    check_val("rerun_ac_lit", dm[12'h010], 8);

    // Store then load.
    do_reset(); clear_im();
    dm[12'h021] = 16'h1234; m_dm[12'h021] = 16'h1234;
    im[0] = ins(4'h1, 8'hAB); im[1] = ins(4'h3, 12'h020); im[2] = ins(4'h2, 12'h021);
    im[3] = ins(4'h3, 12'h022); im[4] = ins(4'hC, 0);
    exec_check("ldst", 0);
    check_val("ldst_st_lit", dm[12'h020], 16'h00AB);
    check_val("ldst_ld_lit", dm[12'h022], 16'h1234);

    // Count-down loop, body runs three times.
    do_reset(); clear_im();
    im[0] = ins(4'h1, 1); im[1] = rins(4'h4, 1); im[2] = ins(4'h1, 3);
    im[3] = rins(4'h7, 1); im[4] = ins(4'h3, 12'h040); im[5] = ins(4'hB, 3);
    im[6] = ins(4'h3, 12'h041); im[7] = ins(4'hC, 0);
    exec_check("loop", 0);
    check_val("loop_ac_lit", dm[12'h041], 0);

    // AC wrap through 0xFFFF + 1, and JPNZ not taken on z=1.
    do_reset(); clear_im();
    im[0] = ins(4'h1, 1); im[1] = rins(4'h4, 1); im[2] = ins(4'h1, 0);
    im[3] = rins(4'h7, 1); im[4] = ins(4'h3, 12'h032); im[5] = ins(4'h9, 0);
    im[6] = ins(4'hB, 12'h00A); im[7] = ins(4'h3, 12'h033); im[8] = ins(4'hC, 0);
    im[10] = ins(4'h3, 12'h034); im[11] = ins(4'hC, 0);
    exec_check("acwrap", 0);
    check_val("acwrap_ff_lit", dm[12'h032], 16'hFFFF);

    // PC wrap: 0xFFF fetch returns to 0, where JPNZ is now taken.
    do_reset(); clear_im();
    im[0] = ins(4'hB, 5); im[1] = ins(4'h9, 0); im[2] = ins(4'hA, 12'hFFF);
    im[5] = ins(4'h3, 12'h030); im[6] = ins(4'hC, 0); im[12'hFFF] = ins(4'h0, 0);
    exec_check("pcwrap", 0);
    check_val("pcwrap_pc_lit", PC_out, 7);

    // Stall across the store's MEM cycle: no write while stalled, one after.
    do_reset(); clear_im();
    im[0] = ins(4'h1, 8'hAB); im[1] = ins(4'h3, 12'h020); im[2] = ins(4'hC, 0);
    exec_check("stall", 2);

    // Reset during the store's MEM cycle.
    do_reset(); clear_im();
    dm[12'h020] = 16'h5555;
    im[0] = ins(4'h1, 8'h77); im[1] = ins(4'h3, 12'h020); im[2] = ins(4'hC, 0);
    run_prog(3, cyc, done);
    check_val("rst_nowrite", got_a.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    m_dm[12'h020] = 16'h5555;

    // MUL (AC=300, r2=300) and out-of-range register index.
    do_reset(); clear_im();
    im[0] = ins(4'h1, 150); im[1] = rins(4'h4, 0); im[2] = rins(4'h6, 0);
    im[3] = rins(4'h4, 2);  im[4] = rins(4'h8, 2); im[5] = ins(4'h3, 12'h030);
    im[6] = rins(4'h4, 6);  im[7] = ins(4'h1, 7);  im[8] = rins(4'h5, 6);
    im[9] = ins(4'h3, 12'h031); im[10] = ins(4'hC, 0);
    exec_check("mul", 0);
`ifdef PROC_CORE_HW_MUL_EN
    mul_exp = 16'h5F90;
`else
    mul_exp = 16'd300;
`endif
    check_val("mul_lit", dm[12'h030], mul_exp);
    check_val("r6_lit", dm[12'h031], 0);

    // Random programs with random stalls, alternating reset and release between runs.
    for (int t = 0; t < 40; t++) begin
      if (t % 2 == 0) do_reset();
      else release_done();
      gen_prog();
      exec_check("rand", t % 3 == 0 ? 0 : 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
